// File: rtl/arb_mux_pkg.sv
// Shared types and helpers for the arbitrating bus multiplexer.
//   arb_mode_t : arbitration policy select (round-robin / fixed priority)
//   next_idx   : modulo-n increment used to advance the round-robin pointer
package arb_mux_pkg;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_t;

    // Increment idx, wrapping to 0 at n (n need not be a power of two)
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/arb_mux_reg_if.sv
// Source/sink bus bundle for arb_mux_reg.
//   in_data/in_valid/in_ready : N producer lanes, lane i at bits [i*WIDTH +: WIDTH]
//   out_data/out_src/out_valid/out_ready : single registered consumer port
//   slave  : view taken by the multiplexer
//   master : view taken by the producers/consumer driving it
interface arb_mux_reg_if #(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 16
);
    logic [N*WIDTH-1:0]     in_data;
    logic [N-1:0]           in_valid;
    logic [N-1:0]           in_ready;
    logic [WIDTH-1:0]       out_data;
    logic [$clog2(N)-1:0]   out_src;
    logic                   out_valid;
    logic                   out_ready;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_src, out_valid
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_src, out_valid
    );
endinterface

// File: rtl/arb_mux_reg_rr_pick.sv
// Combinational rotate-priority encoder.
//   req     : request vector
//   ptr     : highest-priority index in round-robin mode
//   fixed   : 1 = ignore ptr, lowest index wins
//   gnt     : one-hot grant (zero when no request)
//   gnt_idx : index of the granted request
//   any     : at least one request present
module rr_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic                 fixed,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 any
);
    localparam int unsigned IDX_W = $clog2(N);

    // Scan N positions starting at base, wrapping modulo N; first hit wins
    always_comb begin
        int unsigned base;
        int unsigned idx;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        base    = fixed ? 32'd0 : 32'(ptr);
        idx     = 32'd0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = base + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any && req[idx]) begin
                any          = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = IDX_W'(idx);
            end
        end
    end
endmodule

// File: rtl/arb_mux_reg.sv
// N-to-1 arbitrating bus multiplexer with a registered output stage.
//   Clk, Reset_n : clock, asynchronous active-low reset
//   mode         : ARB_RR (round-robin) or ARB_FIXED (lowest index wins)
//   bus          : producer lanes in, registered consumer port out
// One word per cycle throughput: the output register reloads on the same
// edge it drains.
module arb_mux_reg
    import arb_mux_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned N     = 4
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  arb_mode_t     mode,
    arb_mux_reg_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(N);

    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     out_data_q,  out_data_d;
    logic [IDX_W-1:0]     out_src_q,   out_src_d;
    logic [IDX_W-1:0]     ptr_q,       ptr_d;

    logic [N-1:0]         gnt;
    logic [IDX_W-1:0]     gnt_idx;
    logic                 any;
    logic                 fixed;
    logic                 can_load;
    logic                 accept;
    logic [WIDTH-1:0]     sel_data;

    assign fixed = (mode == ARB_FIXED);

    rr_pick #(.N(N)) u_pick (
        .req     (bus.in_valid),
        .ptr     (ptr_q),
        .fixed   (fixed),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    assign can_load = !out_valid_q || bus.out_ready;
    assign accept   = any && can_load;

    // Gated by Reset_n so no source sees a handshake while reset is held
    assign bus.in_ready = (accept && Reset_n) ? gnt : '0;

    // One-hot data select
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt[i]) begin
                sel_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next state of the output register and round-robin pointer
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        ptr_d       = ptr_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_src_d   = gnt_idx;
            if (!fixed) begin
                ptr_d = IDX_W'(next_idx(32'(gnt_idx), N));
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
endmodule

// File: tb/tb_arb_mux_reg.sv
// Testbench for arb_mux_reg: an N=4/WIDTH=16 instance and an N=3/WIDTH=8
// instance run side by side against a behavioural reference model.
module tb_arb_mux_reg;
    import arb_mux_pkg::*;

    logic      Clk = 1'b0;
    logic      Reset_n;
    arb_mode_t mode_a, mode_b;

    arb_mux_reg_if #(.N(4), .WIDTH(16)) ifa ();
    arb_mux_reg_if #(.N(3), .WIDTH(8))  ifb ();

    arb_mux_reg #(.WIDTH(16), .N(4)) u_a (
        .Clk(Clk), .Reset_n(Reset_n), .mode(mode_a), .bus(ifa.slave)
    );
    arb_mux_reg #(.WIDTH(8), .N(3)) u_b (
        .Clk(Clk), .Reset_n(Reset_n), .mode(mode_b), .bus(ifb.slave)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: [0] = N4 instance, [1] = N3 instance
    bit m_val [2];
    int m_data[2];
    int m_src [2];
    int m_ptr [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_val[d] = 1'b0; m_data[d] = 0; m_src[d] = 0; m_ptr[d] = 0;
        end
    endtask

    // First valid index scanning from ptr (or 0 when fixed), modulo n
    function automatic int pick(input int valid, input int n, input int ptr, input bit fixed);
        for (int k = 0; k < n; k++) begin
            int i;
            i = fixed ? k : (ptr + k) % n;
            if (valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic check_outputs();
        chk("a_out_valid", 32'(ifa.out_valid), 32'(m_val[0]));
        chk("a_out_data",  32'(ifa.out_data),  m_data[0]);
        chk("a_out_src",   32'(ifa.out_src),   m_src[0]);
        chk("b_out_valid", 32'(ifb.out_valid), 32'(m_val[1]));
        chk("b_out_data",  32'(ifb.out_data),  m_data[1]);
        chk("b_out_src",   32'(ifb.out_src),   m_src[1]);
    endtask

    // One clock: check in_ready, clock the DUTs and the model, check outputs
    task automatic step();
        int  g[2];
        bit  cl[2];
        int  dat[2];
        bit  fx[2];
        int  exp_rdy;
        #1;
        fx[0] = (mode_a == ARB_FIXED);
        fx[1] = (mode_b == ARB_FIXED);
        g[0]  = pick(32'(ifa.in_valid), 4, m_ptr[0], fx[0]);
        g[1]  = pick(32'(ifb.in_valid), 3, m_ptr[1], fx[1]);
        cl[0] = !m_val[0] || ifa.out_ready;
        cl[1] = !m_val[1] || ifb.out_ready;
        dat[0] = (g[0] >= 0) ? int'((ifa.in_data >> (g[0] * 16)) & 64'hFFFF) : 0;
        dat[1] = (g[1] >= 0) ? int'((ifb.in_data >> (g[1] * 8)) & 24'hFF) : 0;
        exp_rdy = (g[0] >= 0 && cl[0]) ? (1 << g[0]) : 0;
        chk("a_in_ready", 32'(ifa.in_ready), exp_rdy);
        exp_rdy = (g[1] >= 0 && cl[1]) ? (1 << g[1]) : 0;
        chk("b_in_ready", 32'(ifb.in_ready), exp_rdy);
        @(posedge Clk);
        for (int d = 0; d < 2; d++) begin
            if (g[d] >= 0 && cl[d]) begin
                m_val[d]  = 1'b1;
                m_data[d] = dat[d];
                m_src[d]  = g[d];
                if (!fx[d]) m_ptr[d] = (g[d] + 1) % (d == 0 ? 4 : 3);
            end else if (d == 0 ? ifa.out_ready : ifb.out_ready) begin
                m_val[d] = 1'b0;
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic drive(input logic [3:0] va, input logic [2:0] vb, input logic ra, input logic rb);
        ifa.in_valid = va; ifb.in_valid = vb;
        ifa.out_ready = ra; ifb.out_ready = rb;
    endtask

    initial begin
        Reset_n = 1'b0;
        mode_a = ARB_RR; mode_b = ARB_RR;
        drive(4'b0000, 3'b000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ifa.in_data[i*16 +: 16] = 16'h1000 + 16'(i);
        for (int i = 0; i < 3; i++) ifb.in_data[i*8 +: 8] = 8'h20 + 8'(i);
        model_reset();

        // Reset values
        @(posedge Clk); @(posedge Clk); #1;
        check_outputs();
        Reset_n = 1'b1;

        // Round-robin, all valid, full throughput (A: 0,1,2,3,0; B: 0,1,2,0,1)
        drive(4'b1111, 3'b111, 1'b1, 1'b1);
        repeat (5) step();

        // Wrap and skip: move A's ptr to 3, then request 0 and 2
        drive(4'b0100, 3'b010, 1'b1, 1'b1);
        step();
        drive(4'b0101, 3'b101, 1'b1, 1'b1);
        repeat (2) step();

        // Fixed priority holds ptr; RR afterwards resumes from the held ptr
        mode_a = ARB_FIXED; mode_b = ARB_FIXED;
        drive(4'b1110, 3'b110, 1'b1, 1'b1);
        repeat (3) step();
        mode_a = ARB_RR; mode_b = ARB_RR;
        drive(4'b1111, 3'b111, 1'b1, 1'b1);
        step();

        // Back-pressure then release with simultaneous drain and load
        drive(4'b1111, 3'b111, 1'b0, 1'b0);
        repeat (3) step();
        drive(4'b1111, 3'b111, 1'b1, 1'b1);
        repeat (2) step();

        // Asynchronous reset mid-transfer with out_valid high
        drive(4'b0011, 3'b011, 1'b0, 1'b0);
        step();
        #2 Reset_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        chk("a_in_ready_rst", 32'(ifa.in_ready), 32'd0);
        chk("b_in_ready_rst", 32'(ifb.in_ready), 32'd0);
        @(posedge Clk); #1;
        check_outputs();
        drive(4'b1000, 3'b100, 1'b1, 1'b1);
        Reset_n = 1'b1;
        step();

        // Randomized traffic
        for (int t = 0; t < 400; t++) begin
            ifa.in_data = {$urandom, $urandom};
            ifb.in_data = 24'($urandom);
            mode_a = arb_mode_t'($urandom_range(0, 1));
            mode_b = arb_mode_t'($urandom_range(0, 1));
            drive(4'($urandom), 3'($urandom), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 3) != 0));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/arb_mux_reg.md
# arb_mux_reg

Parametrised N-to-1 arbitrating bus multiplexer with a registered output stage.
- Successor to the fixed 4:1 select mux: instead of an externally driven select, it picks among N valid/ready sources by round-robin or fixed priority and holds the result in an output register.
- Sits in the SLC-3 datapath wherever several producers share one consumer, e.g. register-file write-back or MAR/MDR load sources.

## Interface
Parameters:
- WIDTH, 16, data width of each source and of the output.
- N, 4, number of sources; must be ≥ 2.

Ports (clock and reset first):
- Clk  input  1  single clock; all state changes on its rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- mode  input  1  selects the arbitration policy:
  - 0 = round-robin.
  - 1 = fixed priority; the lowest index wins.
- in_data  input  N*WIDTH  source data; source i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  source i presents data.
- in_ready  output  N  source i is accepted this cycle; one-hot or zero.
- out_data  output  WIDTH  registered data.
- out_src  output  $clog2(N)  index of the source that produced out_data.
- out_valid  output  1  out_data and out_src are valid.
- out_ready  input  1  consumer takes the output this cycle.

## Operation
- Output register: out_valid, out_data and out_src.
- Round-robin pointer: ptr, $clog2(N) bits, giving the highest-priority index.
- Output register may load (can_load) when !out_valid || out_ready.
- Grant selection, combinational:
  - Round-robin mode: g = the first index i with in_valid[i] set, scanning ptr, ptr+1, … N-1, then 0 … ptr-1 (modulo-N wrap).
  - Fixed mode: g = the lowest index with in_valid set.
  - No valid source: no grant.
- in_ready[g] = can_load. Every other in_ready bit is 0. All bits are 0 when there is no grant.
- Accept (a grant with can_load):
  - out_data <= in_data[g], out_src <= g, out_valid <= 1.
  - Round-robin mode: ptr <= g+1, wrapping from N-1 to 0.
- Drain: out_ready asserted with no accept → out_valid <= 0. out_data and out_src hold their last value.
- Simultaneous drain and accept: the new word loads and out_valid stays 1, giving full throughput of one word per cycle.
- Fixed mode: ptr holds its value.
- Mode change: takes effect in the same cycle's combinational grant. ptr is not reset.
- A source must hold in_data and in_valid stable until its in_ready is seen. Dropping valid early is a protocol violation and is not checked.
- N not a power of two: ptr wraps at N, never 2^$clog2(N). Indices ≥ N never appear on out_src.

## Timing
- Reset (Reset_n low, asynchronous): out_valid=0, out_data=0, out_src=0, ptr=0. in_ready is 0 on every bit while reset is held.
- Reset mid-transfer: the held word is discarded with no handshake. The first arbitration after release starts at index 0.
- Latency: source accepted at edge k → out_valid high after edge k, visible in cycle k+1.
- in_ready has a combinational path from out_ready and in_valid.
- There is no combinational path from in_data to out_data.
- Output stall (out_valid=1, out_ready=0): all in_ready bits are 0, and out_data, out_src and ptr are frozen.
- Round-robin fairness: with all N sources continuously valid, each source is granted once every N cycles.

## Structure
- Package arb_mux_pkg:
  - typedef enum logic {ARB_RR=1'b0, ARB_FIXED=1'b1} arb_mode_t.
  - Function next_idx(idx, n) implementing the modulo-n increment.
- Sub-module rr_pick:
  - Parameter: N.
  - Inputs: req[N], ptr, fixed.
  - Outputs: gnt one-hot[N], gnt_idx, any.
  - Purely combinational rotate-priority-encode.
- The top level holds the output register, ptr and the handshake logic.

## Test plan
- Reset: assert Reset_n low mid-cycle with out_valid=1 → out_valid=0, out_data=0 and ptr=0 immediately, not waiting for Clk. After release with in_valid=4'b1000, that source is granted first and out_src=3.
- Round-robin: N=4, all valid, out_ready=1, in_data[i]=16'h1000+i → out_src sequence 0,1,2,3,0 with one word per cycle.
- Wrap and skip: ptr=3, in_valid=4'b0101 → source 0 is granted; next grant with the same request is source 2.
- Fixed mode: mode=1, in_valid=4'b1110 held for 3 cycles → out_src=1 each cycle and ptr unchanged.
- Back-pressure: out_ready=0 with out_valid=1 → in_ready=0 and out_data held. Raise out_ready → the held word drains and the next word loads on the same edge, so out_valid stays 1.
- Parameter sweep: N=3, WIDTH=8, all valid → out_src cycles 0,1,2,0 and never shows 3.
